// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: zero-latency hits, 4-word line refill
// through a request/wait memory port, global invalidate via in_Flush.
//
// state | meaning
// IDLE  | serve hits; a miss latches the line address and starts a refill
// FILL  | request words 0..3 of the line in order; last word installs tag/valid
module instruction_cache #(
    parameter int INDEX_BITS = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_CoreRequest,
    input  logic [31:0] in_CoreAddress,
    output logic [31:0] out_CoreBus,
    output logic        out_CoreWait,
    input  logic        in_Flush,
    output logic [31:0] out_MemoryAddress,
    output logic        out_MemoryRequest,
    input  logic [31:0] in_MemoryBus,
    input  logic        in_MemoryWait
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 28 - INDEX_BITS;

    typedef enum logic {IDLE, FILL} state_t;

    state_t                state, state_nxt;
    logic [LINES-1:0]      valid;
    logic [TAG_BITS-1:0]   tag_mem  [LINES];
    logic [31:0]           data_mem [LINES*4];
    logic [27:0]           line_addr;
    logic [1:0]            cnt;
    logic                  flushed;

    logic [INDEX_BITS-1:0] core_index;
    logic [TAG_BITS-1:0]   core_tag;
    logic [1:0]            core_offset;
    logic [INDEX_BITS-1:0] fill_index;
    logic [TAG_BITS-1:0]   fill_tag;
    logic                  hit, xfer, last, miss_start, serve;
    logic                  unused_addr_bits;

    assign core_index       = in_CoreAddress[3+INDEX_BITS:4];
    assign core_tag         = in_CoreAddress[31:4+INDEX_BITS];
    assign core_offset      = in_CoreAddress[3:2];
    assign unused_addr_bits = &{1'b0, in_CoreAddress[1:0]};
    assign fill_index       = line_addr[INDEX_BITS-1:0];
    assign fill_tag         = line_addr[27:INDEX_BITS];

    assign hit        = valid[core_index] && (tag_mem[core_index] == core_tag);
    assign xfer       = (state == FILL) && !in_MemoryWait;
    assign last       = xfer && (cnt == 2'd3);
    // Flush takes the edge; the miss is re-evaluated against cleared valid bits.
    assign miss_start = (state == IDLE) && in_CoreRequest && !hit && !in_Flush;
    assign serve      = in_CoreRequest && (state == IDLE) && hit;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (miss_start) state_nxt = FILL;
            FILL: if (last)       state_nxt = IDLE;
            default:              state_nxt = IDLE;
        endcase
    end

    always_comb begin
        out_CoreWait      = in_CoreRequest && !serve;
        out_CoreBus       = serve ? data_mem[{core_index, core_offset}] : 32'd0;
        out_MemoryRequest = (state == FILL);
        out_MemoryAddress = (state == FILL) ? {line_addr, cnt, 2'b00} : 32'd0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid     <= '0;
            line_addr <= '0;
            cnt       <= 2'd0;
            flushed   <= 1'b0;
        end else begin
            if (miss_start) begin
                line_addr <= in_CoreAddress[31:4];
                cnt       <= 2'd0;
                flushed   <= 1'b0;
            end else begin
                if (xfer) cnt <= cnt + 2'd1;
                if ((state == FILL) && in_Flush) flushed <= 1'b1;
            end
            // A flush seen at any point of the fill keeps the refilled line invalid.
            if (in_Flush) begin
                valid <= '0;
            end else if (last && !flushed) begin
                valid[fill_index] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (xfer) data_mem[{fill_index, cnt}] <= in_MemoryBus;
        if (last) tag_mem[fill_index] <= fill_tag;
    end

endmodule

// File: doc/instruction_cache.md
# instruction_cache

Direct-mapped, read-only instruction cache between the fetch stage and the instruction port of the memory multiplexer. Fetch hits return in the same cycle with no wait. A miss stalls fetch with `out_CoreWait` and refills one 4-word line through the multiplexer's request/wait handshake, one word per accepted transfer. It holds no dirty state and needs no write path. `in_Flush` supports instruction-memory modification by invalidating every line.

## Interface

Parameters
- `INDEX_BITS`, default 4: line index width; the cache holds 2^INDEX_BITS lines of 4 x 32-bit words.

Ports
- `clock`  in  1: single clock; all state changes on the rising edge.
- `reset`  in  1: asynchronous, active-high.
- `in_CoreRequest`  in  1: fetch request valid.
- `in_CoreAddress`  in  32: byte address of the fetch.
  - Bits [1:0] are ignored.
  - [3:2] = word offset; [3+INDEX_BITS:4] = index; [31:4+INDEX_BITS] = tag.
- `out_CoreBus`  out  32: instruction word; valid when `in_CoreRequest`=1 and `out_CoreWait`=0; otherwise 0.
- `out_CoreWait`  out  1: stall to fetch.
- `in_Flush`  in  1: invalidate all lines at this edge.
- `out_MemoryAddress`  out  32: word-aligned refill address to the multiplexer instruction port.
- `out_MemoryRequest`  out  1: refill transfer request.
- `in_MemoryBus`  in  32: refill data.
- `in_MemoryWait`  in  1: multiplexer busy; a transfer completes in any cycle where the request is 1 and wait is 0.

## Operation

Storage
- Per line: one valid bit, one tag, 4 data words.
- Only valid bits are reset; tags and data are don't-care until written.

Hit
- hit = valid[index] and tag[index] equals the address tag.
- Combinational: `out_CoreBus` = data[index][offset]; `out_CoreWait` = `in_CoreRequest` and not (state==IDLE and hit).

State machine
- IDLE:
  - On a miss, latch line address addr[31:4], clear word counter `cnt`, go to FILL.
  - `in_Flush` has priority over starting a fill: the miss is re-evaluated next cycle against empty valid bits.
- FILL:
  - Drive `out_MemoryRequest`=1 and `out_MemoryAddress`={line, cnt, 2'b00}.
  - On a completed transfer, write `in_MemoryBus` to data[line index][cnt] and increment `cnt`.
  - When word 3 completes, write the tag, set valid, and go to IDLE.
  - Words are fetched in order 0..3. There is no critical-word forwarding.

Boundary rules
- `out_MemoryAddress` and `out_MemoryRequest` stay stable while `in_MemoryWait`=1.
- If `in_CoreRequest` drops or the address changes during FILL, the fill still runs to completion; the multiplexer transaction is never abandoned.
- `in_Flush` during FILL:
  - clears all valid bits;
  - the in-progress fill completes its transfers but does not set valid for that line.
- `in_Flush` in the completing cycle of word 3 wins: the line is left invalid.
- A refill overwrites whatever line occupies the index. Tag and data of the old line are replaced.
- Only one outstanding fill exists at a time.

Reset (asynchronous)
- State returns to IDLE, `cnt`=0, and all valid bits are cleared.
- `out_MemoryRequest`=0 and `out_MemoryAddress`=0.
- Combinational outputs with no request: `out_CoreWait`=0 and `out_CoreBus`=0.
- Reset asserted mid-fill drops the request immediately, without waiting for the clock.

## Timing

- Hit latency is 0 cycles; data is valid in the request cycle.
- Miss detected in cycle C0: the request appears in C1.
- With zero-wait memory:
  - words transfer in C1..C4;
  - valid is set at the end of C4;
  - the retried fetch hits in C5, giving a 5-cycle stall.
- Each memory wait cycle adds one stall cycle.
- `out_CoreWait` is 1 in every FILL cycle while a request is present.

## Test plan

1. **Cold miss.** After reset, fetch 0x00000100 with zero-wait memory returning word = address.
   - Requests go to 0x100, 0x104, 0x108, 0x10C in C1..C4.
   - `out_CoreWait`=1 in C0..C4.
   - In C5, `out_CoreWait`=0 and `out_CoreBus`=0x00000100.
2. **Hit sweep.** After test 1, fetch 0x104, 0x108, 0x10C on consecutive cycles.
   - Each cycle has `out_CoreWait`=0 with the matching word.
   - `out_MemoryRequest` stays 0.
3. **Conflict eviction.** With INDEX_BITS=4, fetch 0x100 and then 0x200 (same index, different tag).
   - 0x200 misses and refills from 0x200..0x20C.
   - A re-fetch of 0x100 misses again.
4. **Memory wait.** Hold `in_MemoryWait`=1 for 3 cycles during word 2.
   - Address stays at 0x108 for those cycles.
   - The total stall is 8 cycles.
   - Line data is correct.
5. **Flush.** Assert `in_Flush` mid-fill at word 1.
   - The fill completes all 4 transfers.
   - The next fetch of the same address misses and refills.
   - A flush while idle makes a previously hit line miss.
6. **Reset mid-fill.** Assert `reset` during word 2 with `in_MemoryWait`=1.
   - `out_MemoryRequest` goes to 0 without waiting for a clock edge.
   - After release, a fetch of the same line misses and performs a full 4-word refill.
